// File: rtl/prog_loader.sv
// Program image loader: takes a length/payload/checksum byte frame and writes
// the payload into the CPU RAM write port, holding the CPU in reset until a good image lands.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_data,
    output logic              ld_we,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] count;
    logic [7:0] sum;
    logic       accept;

    function automatic logic [7:0] sum_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LEN;
            S_LEN:  if (accept) state_nxt = S_DATA;
            S_DATA: if (accept && count == 9'd1) state_nxt = S_CSUM;
            S_CSUM: if (accept) state_nxt = (in_data == sum) ? S_DONE : S_ERR;
            S_DONE: if (start) state_nxt = S_LEN;
            S_ERR:  if (start) state_nxt = S_LEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            ld_we        <= 1'b0;
            ld_addr      <= BASE_ADDR;
            ld_data      <= 8'd0;
            cpu_rst_hold <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            count        <= 9'd0;
            sum          <= 8'd0;
        end else begin
            state    <= state_nxt;
            // in_ready follows the state being entered, so it is valid on the first LEN cycle
            in_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);
            ld_we    <= 1'b0;

            // Address holds during the write cycle, then post-increments (wraps naturally)
            if (ld_we) ld_addr <= ld_addr + ADDR_W'(1);

            if (start && (state == S_DONE || state == S_ERR)) begin
                done         <= 1'b0;
                err          <= 1'b0;
                cpu_rst_hold <= 1'b1;
            end

            if (accept) begin
                case (state)
                    S_LEN: begin
                        count   <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        sum     <= 8'd0;
                        ld_addr <= BASE_ADDR;
                    end
                    S_DATA: begin
                        ld_data <= in_data;
                        ld_we   <= 1'b1;
                        sum     <= sum_mod256(sum, in_data);
                        count   <= count - 9'd1;
                    end
                    S_CSUM: begin
                        if (in_data == sum) begin
                            done         <= 1'b1;
                            err          <= 1'b0;
                            cpu_rst_hold <= 1'b0;
                        end else begin
                            done <= 1'b0;
                            err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as bytes are
// driven and popped as ld_we fires; frame outcome flags are checked after each load.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       rdy0, we0, hold0, done0, err0;
    logic [7:0] addr0, data0;
    logic       rdy1, we1, hold1, done1, err1;
    logic [7:0] addr1, data1;

    logic       sel = 1'b0;
    logic       rdy_s, hold_s, done_s, err_s, we_s;
    logic [7:0] addr_s;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] sb[$];
    logic [7:0]  pl[$];
    logic [7:0]  mon_a, mon_d;
    logic [15:0] mon_e;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start && !sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .ld_addr(addr0), .ld_data(data0), .ld_we(we0),
        .cpu_rst_hold(hold0), .done(done0), .err(err0)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut1 (
        .clk(clk), .rst(rst), .start(start && sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .ld_addr(addr1), .ld_data(data1), .ld_we(we1),
        .cpu_rst_hold(hold1), .done(done1), .err(err1)
    );

    assign rdy_s  = sel ? rdy1  : rdy0;
    assign hold_s = sel ? hold1 : hold0;
    assign done_s = sel ? done1 : done0;
    assign err_s  = sel ? err1  : err0;
    assign we_s   = sel ? we1   : we0;
    assign addr_s = sel ? addr1 : addr0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every RAM write must match the next queued expectation
    always @(negedge clk) begin
        if (we0 || we1) begin
            mon_a = we0 ? addr0 : addr1;
            mon_d = we0 ? data0 : data1;
            if (sb.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", {24'd0, mon_a}, {24'd0, mon_e[15:8]});
                chk("wr_data", {24'd0, mon_d}, {24'd0, mon_e[7:0]});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!rdy_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_s) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] csum, input int g, input bit busy);
        logic [7:0] base, s;
        bit good;
        base = sel ? 8'hF0 : 8'h00;
        s = 8'd0;
        foreach (pl[i]) s = s + pl[i];
        good = (s == csum);
        pulse_start();
        chk("start_done", {31'd0, done_s}, 32'd0);
        chk("start_err", {31'd0, err_s}, 32'd0);
        chk("start_hold", {31'd0, hold_s}, 32'd1);
        chk("start_ready", {31'd0, rdy_s}, 32'd1);
        send(8'(pl.size()));
        gap(g);
        for (int i = 0; i < pl.size(); i++) begin
            sb.push_back({8'(base + 8'(i)), pl[i]});
            if (busy && i == 1) start = 1'b1;
            send(pl[i]);
            start = 1'b0;
            gap(g);
        end
        send(csum);
        in_valid = 1'b0;
        chk("end_done", {31'd0, done_s}, {31'd0, good});
        chk("end_err", {31'd0, err_s}, {31'd0, !good});
        chk("end_hold", {31'd0, hold_s}, {31'd0, !good});
        chk("end_ready", {31'd0, rdy_s}, 32'd0);
        @(negedge clk);
        chk("writes_left", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset, with a start pulse coinciding with the final reset edge
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_ready0", {31'd0, rdy0}, 32'd0);
        chk("rst_we0", {31'd0, we0}, 32'd0);
        chk("rst_addr0", {24'd0, addr0}, 32'h00);
        chk("rst_data0", {24'd0, data0}, 32'h00);
        chk("rst_hold0", {31'd0, hold0}, 32'd1);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_addr1", {24'd0, addr1}, 32'hF0);
        chk("rst_hold1", {31'd0, hold1}, 32'd1);
        @(posedge clk); #1;
        chk("idle_ready0", {31'd0, rdy0}, 32'd0);

        // Basic load, bad checksum, recovery
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h66, 0, 1'b0);
        run_frame(8'h65, 0, 1'b0);
        run_frame(8'h66, 0, 1'b0);

        // Gapped stream, then start pulse mid-DATA
        run_frame(8'h66, 2, 1'b0);
        run_frame(8'h66, 0, 1'b1);

        // Reset after two of three payload bytes
        pulse_start();
        send(8'h03);
        sb.push_back({8'h00, 8'h11});
        send(8'h11);
        sb.push_back({8'h01, 8'h22});
        send(8'h22);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, rdy0}, 32'd0);
        chk("mid_rst_we", {31'd0, we0}, 32'd0);
        chk("mid_rst_hold", {31'd0, hold0}, 32'd1);
        chk("mid_rst_done", {31'd0, done0}, 32'd0);
        chk("mid_rst_addr", {24'd0, addr0}, 32'h00);
        chk("mid_rst_writes", sb.size(), 32'd0);
        run_frame(8'h66, 0, 1'b0);

        // Length 0 means 256 bytes, wrapping from 0xF0 through 0xEF
        sel = 1'b1;
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        run_frame(8'h80, 0, 1'b0);
        chk("wrap_final_addr", {24'd0, addr_s}, 32'hF0);
        chk("wrap_we_idle", {31'd0, we_s}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writes a program image into the CPU RAM write port from an external byte stream before the CPU runs.
- It is the writer counterpart of the CPU's instruction-fetch reader.
- While loading, it holds the CPU core in reset. When a valid image has been written and its checksum matches, it releases the CPU.
- Frame format: one length byte, then N payload bytes, then one checksum byte.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, RAM address of the first payload byte.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- ld_addr  out  ADDR_W  RAM write address
- ld_data  out  8  RAM write data
- ld_we  out  1  RAM write enable, one cycle per byte
- cpu_rst_hold  out  1  held high to keep the CPU core in reset
- done  out  1  image loaded and checksum good
- err  out  1  checksum mismatch on the last load

Behaviour:
- Reset: all outputs and state are set synchronously.
  - state=IDLE, in_ready=0, ld_we=0, ld_addr=BASE_ADDR, ld_data=0.
  - cpu_rst_hold=1, done=0, err=0.
  - Internal count=0, sum=0.
- Byte acceptance: a byte is accepted on a rising edge where in_valid && in_ready. in_data must be stable while in_valid is high and in_ready is low.
- in_ready is a registered function of state: 1 in LEN, DATA and CSUM; 0 otherwise. The loader never stalls inside a frame, so the peak rate is one byte per cycle.
- IDLE:
  - start=1 → LEN.
  - Stays here while start=0; cpu_rst_hold stays 1.
- LEN: on accept, count ← (in_data==0) ? 256 : in_data, using a 9-bit counter; sum←0; ld_addr←BASE_ADDR; → DATA.
- DATA, on each accept:
  - ld_data←in_data; ld_we←1 for exactly the next cycle. Write latency is 1 cycle after accept.
  - ld_addr keeps the current address for that write, then post-increments modulo 2^ADDR_W, so an image running past the top of RAM wraps to 0.
  - sum←(sum+in_data) mod 256; count←count−1.
  - When the accepted byte makes count reach 0 → CSUM.
- CSUM, on accept:
  - in_data==sum → DONE: done←1, cpu_rst_hold←0, err←0.
  - Otherwise → ERR: err←1, done←0, cpu_rst_hold stays 1.
  - Bytes already written are not erased.
- DONE and ERR:
  - in_ready=0.
  - start=1 → LEN: done←0, err←0, cpu_rst_hold←1, all on the same edge.
- start is ignored in LEN, DATA and CSUM; it does not restart the frame.
- ld_we is 0 in every cycle that does not follow a DATA accept. The LEN and CSUM bytes are never written to RAM.
- Reset mid-operation returns to the reset values on the next edge. Partially written RAM contents are left as they are.
- Simultaneous rst and start: rst wins.
- Bytes presented while in_ready=0 are not consumed. Upstream must hold them.
- FSM encoding is free. The behaviour above is normative.

Test Plan:
- Basic load, BASE_ADDR=0:
  - Stimulus: start, then stream 0x03, 0x11, 0x22, 0x33, 0x66, with in_valid high continuously.
  - Response: ld_we pulses three times, writing addr0=0x11, addr1=0x22, addr2=0x33.
  - done=1 and cpu_rst_hold=0 one cycle after the 0x66 accept.
- Bad checksum and recovery:
  - Stimulus: the same frame with checksum 0x65.
  - Response: err=1, done=0, cpu_rst_hold=1.
  - Then start and send the good frame: err clears, done=1.
- Gapped stream: the basic frame with in_valid low for 2 cycles between each byte produces identical writes and the same final state. No ld_we fires during the gaps.
- Length 0 with wrap, BASE_ADDR=0xF0:
  - Stimulus: length byte 0x00, then 256 payload bytes with value i for the i-th byte.
  - Response: exactly 256 writes. Address 0xF0 receives 0x00 and address 0xEF receives 0xFF.
  - Correct checksum 0x80 gives done=1.
- Reset mid-DATA:
  - Stimulus: assert rst after 2 of 3 payload bytes.
  - Response: the next cycle shows state IDLE, in_ready=0, ld_we=0, cpu_rst_hold=1, done=0.
  - A following full load succeeds.
- Start while busy: a start pulse during DATA does not reset count or address, and the frame completes normally.
